// File: rtl/bank_arb_pkg.sv
// Shared constants and helpers for the banked-memory access arbiter.
// The optional BANK_ARB_STATS_EN build adds per-requester stall counters of width STAT_W.
package bank_arb_pkg;
   localparam int PKG_ADDR_W    = 12;
   localparam int PKG_BANK_BITS = 2;
   localparam int NUM_BANK      = 2**PKG_BANK_BITS;
   localparam int BANK_AW       = PKG_ADDR_W - PKG_BANK_BITS;
   localparam int STAT_W        = 16;

   function automatic logic [PKG_BANK_BITS-1:0] bank_of(input logic [PKG_ADDR_W-1:0] addr);
      return addr[PKG_ADDR_W-1 -: PKG_BANK_BITS];
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, searching modulo N.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);
   always_comb begin
      int j;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!gnt_any && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bank_access_arbiter.sv
// Per-bank round-robin access arbiter for a 4-bank synchronous SRAM with read-data routing.
// Define BANK_ARB_STATS_EN to add saturating per-requester stall counters (stall_cnt).
module bank_access_arbiter
   import bank_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int ADDR_W    = PKG_ADDR_W,
   parameter  int DATA_W    = 32,
   parameter  int BANK_BITS = PKG_BANK_BITS,
   localparam int NB        = 2**BANK_BITS,
   localparam int BAW       = ADDR_W - BANK_BITS,
   localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [NUM_REQ*DATA_W-1:0] rsp_data,
   output logic [NB-1:0]             bank_en,
   output logic [NB-1:0]             bank_we,
   output logic [NB*BAW-1:0]         bank_addr,
   output logic [NB*DATA_W-1:0]      bank_wdata,
   input  logic [NB*DATA_W-1:0]      bank_rdata
`ifdef BANK_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] stall_cnt
`endif
);
   logic [NUM_REQ-1:0]        cand [NB];
   logic [NUM_REQ-1:0]        gnt [NB];
   logic [IW-1:0]             gnt_idx [NB];
   logic [NB-1:0]             gnt_any;
   logic [IW-1:0]             ptr_q [NB];
   logic [IW-1:0]             ptr_d [NB];
   logic [NB-1:0]             pend_valid_q, pend_valid_d;
   logic [IW-1:0]             pend_req_q [NB];
   logic [IW-1:0]             pend_req_d [NB];
   logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

   always_comb begin
      for (int b = 0; b < NB; b++) begin
         cand[b] = '0;
         for (int i = 0; i < NUM_REQ; i++)
            cand[b][i] = req_valid[i] &&
                         (bank_of(req_addr[i*ADDR_W +: ADDR_W]) == BANK_BITS'(b));
      end
   end

   for (genvar gb = 0; gb < NB; gb++) begin : g_bank
      rr_arbiter #(.N(NUM_REQ)) u_arb (
         .req     (cand[gb]),
         .ptr     (ptr_q[gb]),
         .gnt     (gnt[gb]),
         .gnt_idx (gnt_idx[gb]),
         .gnt_any (gnt_any[gb])
      );
   end

   // Handshake and bank strobes are combinational; they are squashed while reset is low.
   always_comb begin
      req_ready  = '0;
      bank_en    = '0;
      bank_we    = '0;
      bank_addr  = '0;
      bank_wdata = '0;
      for (int b = 0; b < NB; b++) begin
         req_ready                     |= gnt[b];
         bank_en[b]                     = gnt_any[b];
         bank_we[b]                     = gnt_any[b] && req_we[gnt_idx[b]];
         bank_addr[b*BAW +: BAW]        = req_addr[int'(gnt_idx[b])*ADDR_W +: BAW];
         bank_wdata[b*DATA_W +: DATA_W] = req_wdata[int'(gnt_idx[b])*DATA_W +: DATA_W];
      end
      if (!reset) begin
         req_ready = '0;
         bank_en   = '0;
         bank_we   = '0;
      end
   end

   // A requester wins at most one bank per cycle, so bank responses never collide.
   always_comb begin
      rsp_valid_d  = '0;
      rsp_data_d   = rsp_data_q;
      pend_valid_d = '0;
      for (int b = 0; b < NB; b++) begin
         ptr_d[b]        = gnt_any[b] ? IW'((int'(gnt_idx[b]) + 1) % NUM_REQ) : ptr_q[b];
         pend_valid_d[b] = gnt_any[b] && !req_we[gnt_idx[b]];
         pend_req_d[b]   = gnt_idx[b];
         if (pend_valid_q[b]) begin
            rsp_valid_d[pend_req_q[b]]                           = 1'b1;
            rsp_data_d[int'(pend_req_q[b])*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < NB; b++) begin
            ptr_q[b]      <= '0;
            pend_req_q[b] <= '0;
         end
         pend_valid_q <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            ptr_q[b]      <= ptr_d[b];
            pend_req_q[b] <= pend_req_d[b];
         end
         pend_valid_q <= pend_valid_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

`ifdef BANK_ARB_STATS_EN
   logic [NUM_REQ*STAT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_valid[i] && !req_ready[i] && (stall_cnt_q[i*STAT_W +: STAT_W] != '1))
            stall_cnt_d[i*STAT_W +: STAT_W] = stall_cnt_q[i*STAT_W +: STAT_W] + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule
